// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Fixed latency: 32 CALC cycles plus one FIX cycle, with a registered result.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, stateNext;

  logic [CW-1:0]    cnt;
  logic [1:0]       opReg;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             qSign;
  logic             rSign;
  logic             zeroFlag;
  logic             ovfFlag;

  logic             isSigned;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic             lastStep;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] qFix;
  logic [WIDTH-1:0] rFix;
  logic [WIDTH-1:0] resNext;

  assign isSigned = ~op[0];
  assign abs1     = (isSigned && op1[WIDTH-1]) ? -op1 : op1;
  assign abs2     = (isSigned && op2[WIDTH-1]) ? -op2 : op2;
  assign lastStep = (cnt == CW'(WIDTH - 1));
  assign busy     = (state != IDLE);

  // Partial remainder widened by one bit so the trial subtract cannot wrap.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_comb begin
    qFix = qSign ? -quo : quo;
    rFix = rSign ? -rem : rem;
    if (zeroFlag) begin
      qFix = '1;
    end
    if (ovfFlag) begin
      qFix = {1'b1, {(WIDTH-1){1'b0}}};
      rFix = '0;
    end
    resNext = opReg[1] ? rFix : qFix;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = CALC;
      CALC:    if (lastStep) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (flush) begin
      stateNext = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      opReg    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      qSign    <= 1'b0;
      rSign    <= 1'b0;
      zeroFlag <= 1'b0;
      ovfFlag  <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            cnt      <= '0;
            opReg    <= op;
            rem      <= '0;
            quo      <= abs1;
            dvs      <= abs2;
            qSign    <= isSigned & (op1[WIDTH-1] ^ op2[WIDTH-1]);
            rSign    <= isSigned & op1[WIDTH-1];
            zeroFlag <= (op2 == '0);
            ovfFlag  <= isSigned
                        && (op1 == {1'b1, {(WIDTH-1){1'b0}}})
                        && (op2 == '1);
          end
        end
        CALC: begin
          if (!flush) begin
            cnt <= cnt + 1'b1;
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end
        end
        FIX: begin
          if (!flush) begin
            result   <= resNext;
            div_zero <= zeroFlag;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, flush/reset
// aborts, back-to-back issue and randomized ops against an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;

  int checks = 0;
  int failures = 0;

  logic [31:0] lastRes = '0;
  logic        lastDz = 1'b0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .op1(op1),
    .op2(op2),
    .flush(flush),
    .busy(busy),
    .done(done),
    .result(result),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refRes(logic [1:0] o, logic [31:0] a,
                                         logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    refRes = '0;
    case (o)
      2'b00: begin
        if (b == 0) refRes = 32'hFFFF_FFFF;
        else if (ovf) refRes = 32'h8000_0000;
        else refRes = 32'(sa / sb);
      end
      2'b01: begin
        if (b == 0) refRes = 32'hFFFF_FFFF;
        else refRes = a / b;
      end
      2'b10: begin
        if (b == 0) refRes = a;
        else if (ovf) refRes = 32'h0;
        else refRes = 32'(sa % sb);
      end
      default: begin
        if (b == 0) refRes = a;
        else refRes = a % b;
      end
    endcase
  endfunction

  // Caller is at a negedge; start is sampled on the following posedge.
  task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    start = 1'b1;
    op    = o;
    op1   = a;
    op2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    op    = 2'($urandom);
  endtask

  // Ends on the negedge inside the done cycle.
  task automatic waitDone(string tag, logic [31:0] expRes, logic expDz);
    int lat = 0;
    int busyCnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busyCnt++;
    end
    check({tag, "_seen"}, 32'(lat != 0), 32'd1);
    if (lat != 0) begin
      check({tag, "_lat"}, 32'(lat), 32'd34);
      check({tag, "_busyCycles"}, 32'(busyCnt), 32'd33);
      check({tag, "_busyAtDone"}, 32'(busy), 32'd0);
      check({tag, "_result"}, result, expRes);
      check({tag, "_divZero"}, 32'(div_zero), 32'(expDz));
    end
    lastRes = expRes;
    lastDz  = expDz;
  endtask

  task automatic noDone(string tag, int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  logic [1:0]  dOp  [10] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01,
                             2'b11, 2'b00, 2'b11, 2'b00, 2'b10};
  logic [31:0] dA   [10] = '{32'd100, 32'd100, -32'sd100, -32'sd100,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd55, 32'd55,
                             32'h8000_0000, 32'h8000_0000};
  logic [31:0] dB   [10] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd2, 32'd2,
                             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] dExp [10] = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE,
                             32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd55,
                             32'h8000_0000, 32'd0};
  logic        dDz  [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    op1   = '0;
    op2   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_divZero", 32'(div_zero), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(dOp[i], dA[i], dB[i]);
      waitDone($sformatf("dir%0d", i), dExp[i], dDz[i]);
    end

    // Abort mid-CALC: no done, result held.
    @(negedge clk);
    issue(2'b00, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_result", result, lastRes);
    check("flush_divZero", 32'(div_zero), 32'(lastDz));
    noDone("flush_noDone", 40);
    check("flush_resultHeld", result, lastRes);

    // Flush beats a simultaneous start.
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b01;
    op1   = 32'd77;
    op2   = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flushStart_busy", 32'(busy), 32'd0);
    issue(2'b01, 32'd9, 32'd3);
    waitDone("divu9by3", 32'd3, 1'b0);

    // Reset asserted mid-CALC takes effect without a clock edge.
    @(negedge clk);
    issue(2'b00, 32'd12345, 32'd67);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midRst_busy", 32'(busy), 32'd0);
    check("midRst_done", 32'(done), 32'd0);
    check("midRst_result", result, 32'd0);
    check("midRst_divZero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    noDone("midRst_noDone", 40);
    @(negedge clk);
    issue(2'b10, -32'sd12345, 32'd67);
    waitDone("postRst", refRes(2'b10, -32'sd12345, 32'd67), 1'b0);

    // Start during the done cycle is accepted back-to-back.
    issue(2'b01, 32'd1000, 32'd10);
    waitDone("b2b0", 32'd100, 1'b0);
    issue(2'b11, 32'd1003, 32'd10);
    waitDone("b2b1", 32'd3, 1'b0);
    @(negedge clk);
    check("b2b_pulse", 32'(done), 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        2: begin
          a = $urandom_range(0, 1000);
          b = $urandom_range(1, 40);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        3: b = 32'($urandom_range(1, 65535));
        default: ;
      endcase
      @(negedge clk);
      issue(o, a, b);
      waitDone($sformatf("rnd%0d_op%0d_%h_%h", n, o, a, b),
               refRes(o, a, b), b == 0);
      @(negedge clk);
      check("rnd_pulse", 32'(done), 32'd0);
      check("rnd_hold", result, lastRes);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
